// File: rtl/cdb_arbiter_pkg.sv
// Shared processor definitions for the result broadcast path.
// Tag/index widths, FU count and FU slot numbering.
package cdb_arbiter_pkg;

  localparam int NUM_FU  = 3;
  localparam int PRF_IDX = 6;
  localparam int ROB_IDX = 5;
  localparam int DATA_W  = 64;

  localparam int FU_ALU  = 0;
  localparam int FU_MULT = 1;
  localparam int FU_MEM  = 2;

  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr_arbiter.sv
// Round-robin arbiter: first requester at or above ptr, wrapping.
// Pure combinational; reusable by any scheduler.
module rr_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  logic found;
  int   idx;

  // Scan upward from ptr modulo N, grant the first request seen
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one result buffer per FU,
// round-robin broadcast of one buffered result per cycle.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_FU  = cdb_arbiter_pkg::NUM_FU,
  parameter int PRF_IDX = cdb_arbiter_pkg::PRF_IDX,
  parameter int ROB_IDX = cdb_arbiter_pkg::ROB_IDX,
  parameter int DATA_W  = cdb_arbiter_pkg::DATA_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_FU-1:0]         fu_done,
  input  logic [NUM_FU*PRF_IDX-1:0] fu_tag,
  input  logic [NUM_FU*ROB_IDX-1:0] fu_rob_idx,
  input  logic [NUM_FU*DATA_W-1:0]  fu_value,
  input  logic                      flush,
  output logic [NUM_FU-1:0]         fu_free,
  output logic                      cdb_valid,
  output logic [PRF_IDX-1:0]        cdb_tag,
  output logic [ROB_IDX-1:0]        cdb_rob_idx,
  output logic [DATA_W-1:0]         cdb_value
);

  localparam int PW = ptr_w(NUM_FU);

  logic [NUM_FU-1:0]  buf_valid;
  logic [PRF_IDX-1:0] buf_tag   [NUM_FU];
  logic [ROB_IDX-1:0] buf_rob   [NUM_FU];
  logic [DATA_W-1:0]  buf_value [NUM_FU];
  logic [PW-1:0]      rr_ptr;
  logic [PW-1:0]      ptr_next;
  logic [NUM_FU-1:0]  grant;
  logic [NUM_FU-1:0]  load;
  logic               active;

  rr_arbiter #(
    .N  (NUM_FU),
    .PW (PW)
  ) u_rr (
    .req (buf_valid),
    .ptr (rr_ptr),
    .gnt (grant)
  );

  assign active    = ~flush & ~reset;
  assign fu_free   = (~buf_valid | grant) & {NUM_FU{active}};
  assign load      = fu_done & fu_free;
  assign cdb_valid = (|grant) & active;

  // Broadcast the granted buffer; all-zero when nothing goes out
  always_comb begin
    cdb_tag     = '0;
    cdb_rob_idx = '0;
    cdb_value   = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (cdb_valid && grant[i]) begin
        cdb_tag     = buf_tag[i];
        cdb_rob_idx = buf_rob[i];
        cdb_value   = buf_value[i];
      end
    end
  end

  // Pointer moves just past the winner; idle cycles hold it
  always_comb begin
    ptr_next = rr_ptr;
    for (int i = 0; i < NUM_FU; i++) begin
      if (grant[i])
        ptr_next = (i == NUM_FU - 1) ? '0 : PW'(i + 1);
    end
  end

  // Buffer fill/drain and pointer state
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_valid <= '0;
      rr_ptr    <= '0;
      for (int i = 0; i < NUM_FU; i++) begin
        buf_tag[i]   <= '0;
        buf_rob[i]   <= '0;
        buf_value[i] <= '0;
      end
    end else if (flush) begin
      buf_valid <= '0;
    end else begin
      rr_ptr <= ptr_next;
      for (int i = 0; i < NUM_FU; i++) begin
        if (load[i]) begin
          buf_valid[i] <= 1'b1;
          buf_tag[i]   <= fu_tag[i*PRF_IDX +: PRF_IDX];
          buf_rob[i]   <= fu_rob_idx[i*ROB_IDX +: ROB_IDX];
          buf_value[i] <= fu_value[i*DATA_W +: DATA_W];
        end else if (grant[i]) begin
          buf_valid[i] <= 1'b0;
        end
      end
    end
  end

  // A result offered to a busy slot is dropped; flag it
  always_ff @(posedge clk) begin
    if (!reset && !flush)
      assert ((fu_done & ~fu_free) == '0)
      else $warning("cdb_arbiter: fu_done on busy FU %b dropped",
                    fu_done & ~fu_free);
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter.
// Inputs change after posedge, outputs checked at negedge.
module tb_cdb_arbiter;

  logic         clk;
  logic         reset;
  logic [2:0]   fu_done;
  logic [17:0]  fu_tag;
  logic [14:0]  fu_rob_idx;
  logic [191:0] fu_value;
  logic         flush;
  logic [2:0]   fu_free;
  logic         cdb_valid;
  logic [5:0]   cdb_tag;
  logic [4:0]   cdb_rob_idx;
  logic [63:0]  cdb_value;

  int total;
  int passed;

  cdb_arbiter #(
    .NUM_FU  (3),
    .PRF_IDX (6),
    .ROB_IDX (5),
    .DATA_W  (64)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .fu_done     (fu_done),
    .fu_tag      (fu_tag),
    .fu_rob_idx  (fu_rob_idx),
    .fu_value    (fu_value),
    .flush       (flush),
    .fu_free     (fu_free),
    .cdb_valid   (cdb_valid),
    .cdb_tag     (cdb_tag),
    .cdb_rob_idx (cdb_rob_idx),
    .cdb_value   (cdb_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive(input int i, input logic [5:0] t,
                       input logic [4:0] r, input logic [63:0] v);
    fu_tag[i*6 +: 6]      = t;
    fu_rob_idx[i*5 +: 5]  = r;
    fu_value[i*64 +: 64]  = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    passed = 0;
    reset = 1'b1;
    flush = 1'b0;
    fu_done = 3'b111;
    fu_tag = '0;
    fu_rob_idx = '0;
    fu_value = '0;
    drive(0, 6'd9, 5'd9, 64'h99);

    // reset held, fu_done ignored
    @(negedge clk);
    chk("rst_valid", cdb_valid, 0);
    chk("rst_free", fu_free, 0);
    chk("rst_tag", cdb_tag, 0);
    chk("rst_value", cdb_value, 0);
    tick();
    reset = 1'b0;
    fu_done = 3'b000;
    @(negedge clk);
    chk("post_rst_free", fu_free, 3'b111);
    chk("post_rst_valid", cdb_valid, 0);
    chk("post_rst_ptr", dut.rr_ptr, 0);

    // single ALU result, 1-cycle latency
    tick();
    fu_done = 3'b001;
    drive(0, 6'd5, 5'd3, 64'hAB);
    @(negedge clk);
    chk("alu_lat0", cdb_valid, 0);
    tick();
    fu_done = 3'b000;
    @(negedge clk);
    chk("alu_valid", cdb_valid, 1);
    chk("alu_tag", cdb_tag, 5);
    chk("alu_rob", cdb_rob_idx, 3);
    chk("alu_value", cdb_value, 64'hAB);
    chk("alu_free0", fu_free[0], 1);

    // MEM alone, pointer wraps back to 0
    tick();
    fu_done = 3'b100;
    drive(2, 6'd7, 5'd1, 64'h77);
    @(negedge clk);
    chk("ptr_after_alu", dut.rr_ptr, 1);
    tick();
    fu_done = 3'b000;
    @(negedge clk);
    chk("mem_tag", cdb_tag, 7);
    tick();
    @(negedge clk);
    chk("ptr_wrap", dut.rr_ptr, 0);

    // all three at once
    fu_done = 3'b111;
    drive(0, 6'd1, 5'd1, 64'h10);
    drive(1, 6'd2, 5'd2, 64'h20);
    drive(2, 6'd3, 5'd3, 64'h30);
    tick();
    fu_done = 3'b000;
    @(negedge clk);
    chk("all_c1_tag", cdb_tag, 1);
    chk("all_c1_free", fu_free, 3'b001);
    tick();
    @(negedge clk);
    chk("all_c2_tag", cdb_tag, 2);
    chk("all_c2_value", cdb_value, 64'h20);
    chk("all_c2_free", fu_free, 3'b011);
    tick();
    @(negedge clk);
    chk("all_c3_tag", cdb_tag, 3);
    chk("all_c3_free", fu_free, 3'b111);
    tick();
    @(negedge clk);
    chk("all_done_valid", cdb_valid, 0);
    chk("all_done_ptr", dut.rr_ptr, 0);

    // flush with two buffers valid
    fu_done = 3'b011;
    drive(0, 6'h11, 5'd4, 64'h111);
    drive(1, 6'h12, 5'd5, 64'h112);
    tick();
    fu_done = 3'b100;
    drive(2, 6'h13, 5'd6, 64'h113);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_valid", cdb_valid, 0);
    chk("flush_free", fu_free, 3'b000);
    chk("flush_tag", cdb_tag, 0);
    tick();
    fu_done = 3'b000;
    flush = 1'b0;
    @(negedge clk);
    chk("postflush_valid", cdb_valid, 0);
    chk("postflush_free", fu_free, 3'b111);
    chk("postflush_ptr", dut.rr_ptr, 0);

    // protocol violation on losing MULT slot
    tick();
    fu_done = 3'b011;
    drive(0, 6'h21, 5'd7, 64'h221);
    drive(1, 6'h22, 5'd8, 64'h222);
    tick();
    fu_done = 3'b010;
    drive(1, 6'd9, 5'd9, 64'h999);
    @(negedge clk);
    chk("viol_free", fu_free, 3'b101);
    chk("viol_c1_tag", cdb_tag, 6'h21);
    tick();
    fu_done = 3'b000;
    @(negedge clk);
    chk("viol_c2_tag", cdb_tag, 6'h22);
    chk("viol_c2_value", cdb_value, 64'h222);
    tick();
    @(negedge clk);
    chk("viol_done_valid", cdb_valid, 0);
    chk("viol_ptr", dut.rr_ptr, 2);

    // fairness: ALU and MEM refill whenever free, ptr starts at 2
    fu_done = 3'b101;
    drive(0, 6'h30, 5'd0, 64'h30);
    drive(2, 6'h31, 5'd0, 64'h31);
    tick();
    fu_done = 3'b100;
    drive(2, 6'h32, 5'd0, 64'h32);
    @(negedge clk);
    chk("fair_b_tag", cdb_tag, 6'h31);
    chk("fair_b_free", fu_free, 3'b110);
    tick();
    fu_done = 3'b001;
    drive(0, 6'h33, 5'd0, 64'h33);
    @(negedge clk);
    chk("fair_c_ptr", dut.rr_ptr, 0);
    chk("fair_c_tag", cdb_tag, 6'h30);
    chk("fair_c_free", fu_free, 3'b011);
    tick();
    fu_done = 3'b100;
    drive(2, 6'h34, 5'd0, 64'h34);
    @(negedge clk);
    chk("fair_d_tag", cdb_tag, 6'h32);
    chk("fair_d_free", fu_free, 3'b110);
    tick();
    fu_done = 3'b000;
    @(negedge clk);
    chk("fair_e_tag", cdb_tag, 6'h33);
    tick();
    @(negedge clk);
    chk("fair_f_tag", cdb_tag, 6'h34);
    tick();
    @(negedge clk);
    chk("fair_g_valid", cdb_valid, 0);

    // reset with all buffers valid
    fu_done = 3'b111;
    drive(0, 6'h3A, 5'd1, 64'h1);
    drive(1, 6'h3B, 5'd2, 64'h2);
    drive(2, 6'h3C, 5'd3, 64'h3);
    tick();
    fu_done = 3'b000;
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_valid", cdb_valid, 0);
    chk("midrst_free", fu_free, 3'b000);
    tick();
    fu_done = 3'b111;
    @(negedge clk);
    chk("midrst2_valid", cdb_valid, 0);
    tick();
    reset = 1'b0;
    fu_done = 3'b000;
    @(negedge clk);
    chk("relrst_free", fu_free, 3'b111);
    chk("relrst_valid", cdb_valid, 0);
    chk("relrst_ptr", dut.rr_ptr, 0);
    tick();
    @(negedge clk);
    chk("relrst_nostale", cdb_valid, 0);
    chk("relrst_tag", cdb_tag, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter NUM_FU, default 3, meaning number of functional-unit result sources; index 0=ALU, 1=MULT, 2=MEM.
REQ-002 SHALL have parameter PRF_IDX, default 6, meaning physical register tag width.
REQ-003 SHALL have parameter ROB_IDX, default 5, meaning ROB index width.
REQ-004 SHALL have parameter DATA_W, default 64, meaning result width.
REQ-005 SHALL use clock clk and reset reset, synchronous, active-high.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 reset  in  1  synchronous active-high reset.
REQ-008 fu_done  in  NUM_FU  FU i presents a completed result this cycle.
REQ-009 fu_tag  in  NUM_FU*PRF_IDX  destination physical tag per FU, FU i in bits [i*PRF_IDX +: PRF_IDX].
REQ-010 fu_rob_idx  in  NUM_FU*ROB_IDX  ROB entry per FU, same packing.
REQ-011 fu_value  in  NUM_FU*DATA_W  result value per FU, same packing.
REQ-012 flush  in  1  mispredict squash; discards all buffered results.
REQ-013 fu_free  out  NUM_FU  FU i may assert fu_done this cycle; drives the RS ALU_free/mult_free/mem_free inputs.
REQ-014 cdb_valid  out  1  broadcast valid.
REQ-015 cdb_tag  out  PRF_IDX  broadcast tag.
REQ-016 cdb_rob_idx  out  ROB_IDX  broadcast ROB index.
REQ-017 cdb_value  out  DATA_W  broadcast value.

Function
REQ-018 Each FU SHALL own a one-entry result buffer: valid bit plus tag, rob_idx, value.
REQ-019 Buffer i SHALL load on a clock edge when fu_done[i]=1, flush=0, and (buffer empty or grant[i]=1 this cycle).
REQ-020 grant SHALL be one-hot or zero: the first valid buffer found searching upward from rr_ptr, modulo NUM_FU.
REQ-021 cdb_* SHALL be driven combinationally from the granted buffer; cdb_valid = |grant & !flush & !reset.
REQ-022 A granted buffer SHALL clear at the next edge unless reloaded per REQ-019; latency from fu_done to cdb_valid SHALL be exactly 1 cycle when uncontended.
REQ-023 On a grant to i with flush=0, rr_ptr SHALL become (i+1) mod NUM_FU; i=NUM_FU-1 SHALL wrap to 0; no grant SHALL leave rr_ptr unchanged.
REQ-024 fu_free[i] SHALL equal (!buf_valid[i] | grant[i]) & !flush & !reset.
REQ-025 fu_done[i] while fu_free[i]=0 SHALL be a protocol violation: buffer contents SHALL be retained and the new result dropped; a simulation assertion SHALL fire.
REQ-026 flush=1 SHALL clear every buffer valid at the edge, SHALL ignore fu_done that cycle, SHALL force cdb_valid=0 that cycle, and SHALL leave rr_ptr unchanged.
REQ-027 When no buffer is valid, cdb_valid SHALL be 0 and cdb_tag/rob_idx/value SHALL be 0.
REQ-028 Any continuously valid buffer SHALL be granted within NUM_FU cycles (no starvation).

Reset
REQ-029 At a reset edge, all buffer valids SHALL clear, buffer payloads SHALL clear to 0, and rr_ptr SHALL become 0.
REQ-030 While reset=1: cdb_valid=0, cdb_tag/rob_idx/value=0, fu_free=0; fu_done SHALL be ignored.
REQ-031 On the first cycle after reset deasserts, fu_free SHALL be all ones and cdb_valid SHALL be 0.
REQ-032 Reset asserted mid-contention SHALL discard all pending results without broadcast.

Structure
REQ-033 PRF_IDX, ROB_IDX, NUM_FU and FU index constants (FU_ALU=0, FU_MULT=1, FU_MEM=2) SHALL live in the shared processor definitions header.
REQ-034 Arbitration SHALL be a sub-module rr_arbiter (req, ptr -> one-hot gnt), parameterised by width and reusable by other schedulers.
REQ-035 Buffers and rr_ptr SHALL be the only state; outputs SHALL be combinational from that state, flush and reset.

Verification
REQ-036 ALU fu_done with tag=5, rob=3, value=0xAB at cycle 1 -> next cycle cdb_valid=1, tag=5, rob=3, value=0xAB; fu_free[0]=1.
REQ-037 All three FUs done in the same cycle, rr_ptr=0 -> broadcasts ALU, MULT, MEM on three consecutive cycles; fu_free=3'b001, 3'b011, 3'b111 during those cycles; rr_ptr=0 afterwards.
REQ-038 MEM granted (rr_ptr wraps 2->0) while ALU and MEM redo fu_done every cycle -> grants alternate ALU, MULT-if-valid, MEM with none waiting more than 3 cycles.
REQ-039 Two buffers valid, flush=1 -> that cycle cdb_valid=0, fu_free=0; next cycle all buffers empty, fu_free=3'b111, rr_ptr unchanged.
REQ-040 MULT buffer valid and losing arbitration, MULT asserts fu_done with tag=9 -> assertion fires; original MULT tag broadcast later, tag 9 never broadcast.
REQ-041 reset asserted with all buffers valid -> cdb_valid=0 throughout; after release fu_free=3'b111, no stale broadcast.
